// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions used by the writeback path.
//   REG_IDX_W   : width of a register index
//   REG_COUNT   : number of architectural registers
//   NUM_REQ     : number of writeback requesters
//   reg_idx_t   : register index type
//   requester_e : writeback requester identity (ALU, load unit)
package mips_cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;
    localparam int NUM_REQ   = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Enum values double as bit positions in request/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } requester_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter for register-file writeback.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : requests, bit 0 = ALU, bit 1 = load
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and pointer
// FAIR=1 alternates on contested cycles using a last-winner pointer;
// FAIR=0 always favours the load requester.
module rr_arb2
    import mips_cpu_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    requester_e last_win_r;
    requester_e winner_s;
    logic       contested_s;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        gnt         = 2'b00;
        winner_s    = REQ_ALU;
        contested_s = 1'b0;
        if (rst) begin
            gnt = 2'b00;
        end else begin
            case (req)
                2'b01: begin
                    winner_s = REQ_ALU;
                    gnt      = 2'b01;
                end
                2'b10: begin
                    winner_s = REQ_LD;
                    gnt      = 2'b10;
                end
                2'b11: begin
                    contested_s = 1'b1;
                    if (FAIR != 0) begin
                        if (last_win_r == REQ_ALU) begin
                            winner_s = REQ_LD;
                        end else begin
                            winner_s = REQ_ALU;
                        end
                    end else begin
                        winner_s = REQ_LD;
                    end
                    if (winner_s == REQ_LD) begin
                        gnt = 2'b10;
                    end else begin
                        gnt = 2'b01;
                    end
                end
                default: begin
                    gnt = 2'b00;
                end
            endcase
        end
    end

    // Last-winner pointer: reset value LD makes the first contest go to ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_win_r <= REQ_LD;
        end else if (contested_s) begin
            last_win_r <= winner_s;
        end else begin
            last_win_r <= last_win_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_dest/alu_data       : ALU writeback request
//   alu_ready                         : ALU request accepted this cycle
//   ld_valid/ld_dest/ld_data          : load writeback request
//   ld_ready                          : load request accepted this cycle
//   rsv_valid/rsv_dest                : issue-stage reservation of a destination
//   rf_wren/rf_wr/rf_wd               : registered register-file write port
//   pending[31:0]                     : registers with an outstanding write
module regfile_wb_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FAIR   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ld_valid,
    input  logic [4:0]           ld_dest,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_dest,
    output logic                 rf_wren,
    output logic [4:0]           rf_wr,
    output logic [DATA_W-1:0]    rf_wd,
    output logic [REG_COUNT-1:0] pending
);

    logic [NUM_REQ-1:0]   req_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 xfer_s;
    reg_idx_t             dest_s;
    logic [DATA_W-1:0]    data_s;
    logic [REG_COUNT-1:0] pending_next_s;

    logic                 rf_wren_r;
    reg_idx_t             rf_wr_r;
    logic [DATA_W-1:0]    rf_wd_r;
    logic [REG_COUNT-1:0] pending_r;

    assign req_s = {ld_valid, alu_valid};

    rr_arb2 #(
        .FAIR (FAIR)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_s),
        .gnt (gnt_s)
    );

    assign alu_ready = gnt_s[0];
    assign ld_ready  = gnt_s[1];

    // Winning request mux.
    always_comb begin
        xfer_s = |gnt_s;
        dest_s = alu_dest;
        data_s = alu_data;
        if (gnt_s[1]) begin
            dest_s = ld_dest;
            data_s = ld_data;
        end else begin
            dest_s = alu_dest;
            data_s = alu_data;
        end
    end

    // Scoreboard update: completion clears first so a same-cycle reservation wins.
    always_comb begin
        pending_next_s = pending_r;
        if (xfer_s && (dest_s != 5'd0)) begin
            pending_next_s[dest_s] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (rsv_valid && (rsv_dest != 5'd0)) begin
            pending_next_s[rsv_dest] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Registered write port and scoreboard; writes to r0 are accepted but dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wren_r <= 1'b0;
            rf_wr_r   <= 5'd0;
            rf_wd_r   <= {DATA_W{1'b0}};
            pending_r <= {REG_COUNT{1'b0}};
        end else begin
            rf_wren_r <= xfer_s && (dest_s != 5'd0);
            if (xfer_s) begin
                rf_wr_r <= dest_s;
                rf_wd_r <= data_s;
            end else begin
                rf_wr_r <= rf_wr_r;
                rf_wd_r <= rf_wd_r;
            end
            pending_r <= pending_next_s;
        end
    end

    assign rf_wren = rf_wren_r;
    assign rf_wr   = rf_wr_r;
    assign rf_wd   = rf_wd_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share the same stimulus.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, rsv_valid;
    logic [4:0]  alu_dest, ld_dest, rsv_dest;
    logic [31:0] alu_data, ld_data;

    logic        alu_ready, ld_ready, rf_wren;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd, pending;

    logic        fp_alu_ready, fp_ld_ready, fp_rf_wren;
    logic [4:0]  fp_rf_wr;
    logic [31:0] fp_rf_wd, fp_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest),
        .rf_wren(rf_wren), .rf_wr(rf_wr), .rf_wd(rf_wd), .pending(pending)
    );

    regfile_wb_arbiter #(.DATA_W(32), .FAIR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(fp_ld_ready),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest),
        .rf_wren(fp_rf_wren), .rf_wr(fp_rf_wr), .rf_wd(fp_rf_wd), .pending(fp_pending)
    );

    // Advance past a rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; ld_valid = 1'b0; rsv_valid = 1'b0;
        alu_dest = 5'd0; ld_dest = 5'd0; rsv_dest = 5'd0;
        alu_data = 32'h0; ld_data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h1111_1111;
        ld_valid = 1'b1;  ld_dest = 5'd4;  ld_data = 32'h2222_2222;
        rsv_valid = 1'b1; rsv_dest = 5'd3;
        #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b want 0", alu_ready); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        step(); step();
        checks++; if (rf_wren !== 1'b0) begin errors++; $display("FAIL reset_rf_wren got %b want 0", rf_wren); end
        checks++; if (rf_wr !== 5'd0) begin errors++; $display("FAIL reset_rf_wr got %0d want 0", rf_wr); end
        checks++; if (rf_wd !== 32'h0) begin errors++; $display("FAIL reset_rf_wd got %h want 0", rf_wd); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b want 1", alu_ready); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL single_ld_ready got %b want 0", ld_ready); end
        checks++; if (fp_alu_ready !== 1'b1) begin errors++; $display("FAIL single_fp_alu_ready got %b want 1", fp_alu_ready); end
        step();
        idle_inputs();
        checks++; if (rf_wren !== 1'b1) begin errors++; $display("FAIL single_rf_wren got %b want 1", rf_wren); end
        checks++; if (rf_wr !== 5'd5) begin errors++; $display("FAIL single_rf_wr got %0d want 5", rf_wr); end
        checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf_wd got %h want deadbeef", rf_wd); end
        step();
        checks++; if (rf_wren !== 1'b0) begin errors++; $display("FAIL idle_rf_wren got %b want 0", rf_wren); end
        checks++; if (rf_wr !== 5'd5) begin errors++; $display("FAIL idle_rf_wr_hold got %0d want 5", rf_wr); end
        checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_rf_wd_hold got %h want deadbeef", rf_wd); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_alu;
        exp_alu = 4'b0101; // cycle 0 ALU, 1 LD, 2 ALU, 3 LD
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hA0A0_0003;
        ld_valid = 1'b1;  ld_dest = 5'd4;  ld_data = 32'hB0B0_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (alu_ready !== exp_alu[i]) begin errors++; $display("FAIL rr_alu_ready[%0d] got %b want %b", i, alu_ready, exp_alu[i]); end
            checks++; if (ld_ready !== ~exp_alu[i]) begin errors++; $display("FAIL rr_ld_ready[%0d] got %b want %b", i, ld_ready, ~exp_alu[i]); end
            checks++; if (fp_ld_ready !== 1'b1 || fp_alu_ready !== 1'b0) begin errors++; $display("FAIL fp_ready[%0d] got ld=%b alu=%b want ld=1 alu=0", i, fp_ld_ready, fp_alu_ready); end
            step();
            checks++; if (rf_wr !== (exp_alu[i] ? 5'd3 : 5'd4) || rf_wren !== 1'b1) begin errors++; $display("FAIL rr_rf_wr[%0d] got %0d wren=%b want %0d wren=1", i, rf_wr, rf_wren, exp_alu[i] ? 3 : 4); end
            checks++; if (rf_wd !== (exp_alu[i] ? 32'hA0A0_0003 : 32'hB0B0_0004)) begin errors++; $display("FAIL rr_rf_wd[%0d] got %h", i, rf_wd); end
            checks++; if (fp_rf_wr !== 5'd4) begin errors++; $display("FAIL fp_rf_wr[%0d] got %0d want 4", i, fp_rf_wr); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_pending_lifetime();
        rsv_valid = 1'b1; rsv_dest = 5'd7;
        step();
        rsv_valid = 1'b0;
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL pend7_c1 got %h want 00000080", pending); end
        step();
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL pend7_c2 got %h want 00000080", pending); end
        ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h0000_0777;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL pend7_ld_ready got %b want 1", ld_ready); end
        step();
        idle_inputs();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL pend7_clear got %h want 0", pending); end
        checks++; if (rf_wren !== 1'b1 || rf_wr !== 5'd7) begin errors++; $display("FAIL pend7_write got wren=%b wr=%0d want 1/7", rf_wren, rf_wr); end
    endtask

    task automatic test_same_cycle();
        rsv_valid = 1'b1; rsv_dest = 5'd9;
        step();
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL same_pre got %h want 00000200", pending); end
        alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h0000_0099;
        step();
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL same_set_wins got %h want 00000200", pending); end
        checks++; if (rf_wren !== 1'b1 || rf_wr !== 5'd9) begin errors++; $display("FAIL same_write got wren=%b wr=%0d want 1/9", rf_wren, rf_wr); end
        rsv_dest = 5'd10;
        step();
        checks++; if (pending !== 32'h0000_0400) begin errors++; $display("FAIL indep got %h want 00000400", pending); end
        rsv_valid = 1'b0; alu_dest = 5'd10;
        step();
        idle_inputs();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL indep_clear got %h want 0", pending); end
    endtask

    task automatic test_reg_zero();
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h0000_1234;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", alu_ready); end
        step();
        idle_inputs();
        checks++; if (rf_wren !== 1'b0) begin errors++; $display("FAIL r0_wren got %b want 0", rf_wren); end
        rsv_valid = 1'b1; rsv_dest = 5'd0;
        step();
        idle_inputs();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL r0_rsv got %h want 0", pending); end
    endtask

    task automatic test_reset_midflight();
        rsv_valid = 1'b1; rsv_dest = 5'd11;
        step();
        rsv_valid = 1'b0;
        // Contested: pointer last saw LD win, so ALU wins here and LD is favoured next.
        alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'h0000_0666;
        ld_valid = 1'b1;  ld_dest = 5'd8;  ld_data = 32'h0000_0888;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL mid_alu_ready got %b want 1", alu_ready); end
        step();
        checks++; if (rf_wren !== 1'b1 || pending !== 32'h0000_0800) begin errors++; $display("FAIL mid_inflight got wren=%b pend=%h want 1/00000800", rf_wren, pending); end
        rst = 1'b1;
        #1;
        checks++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got alu=%b ld=%b want 0/0", alu_ready, ld_ready); end
        step();
        checks++; if (rf_wren !== 1'b0 || pending !== 32'h0) begin errors++; $display("FAIL mid_rst_flush got wren=%b pend=%h want 0/0", rf_wren, pending); end
        rst = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL post_rst_ptr got alu=%b ld=%b want 1/0", alu_ready, ld_ready); end
        step();
        idle_inputs();
        checks++; if (rf_wr !== 5'd6) begin errors++; $display("FAIL post_rst_wr got %0d want 6", rf_wr); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_round_robin();
        test_pending_lifetime();
        test_same_cycle();
        test_reg_zero();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
